// File: rtl/linebuf_pkg.sv
// Shared types and limits for the N-row line buffer.
// LINEBUF_REPLICATE_EN (top level) enables top-border replication while the buffer fills.
package linebuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } lb_state_e;

    localparam int ROWS_MIN = 2;
    localparam int ROWS_MAX = 8;

    localparam int PIX_W = 16;
    typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/linebuf_ram.sv
// Single-port line RAM: read-before-write with a registered read port.
// old_o exposes the pre-write contents at addr_i so the next RAM in the chain can take them.
module linebuf_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] old_o,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    assign old_o   = mem_q[addr_i];
    assign rdata_o = rdata_q;

    // Storage array carries no reset; only the read register does.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/linebuf_nrow.sv
// N-row line buffer: presents a vertical column of ROWS pixels per accepted pixel.
// Define LINEBUF_REPLICATE_EN to emit columns during fill with the top border replicated.
module linebuf_nrow
    import linebuf_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_LEN    = 128,
    parameter int ROWS       = 3,
    localparam int ADDR_WIDTH = $clog2(MAX_LEN),
    localparam int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LEN_WIDTH-1:0]       line_len,
    input  logic                       sof,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [ROWS*DATA_WIDTH-1:0] data_out,
    output logic                       out_valid,
    output logic [ADDR_WIDTH-1:0]      out_col,
    output logic                       out_eol
);

    localparam int LCNT_W = $clog2(ROWS);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX   = LEN_WIDTH'(MAX_LEN);
    localparam logic [LCNT_W-1:0]    LAST_LINE = LCNT_W'(ROWS - 1);
    localparam logic [LCNT_W-1:0]    PRE_LAST  = LCNT_W'(ROWS - 2);
`ifdef LINEBUF_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    lb_state_e             state_q, state_d, eff_state;
    logic [ADDR_WIDTH-1:0] col_q, col_d, cur_col;
    logic [LCNT_W-1:0]     line_q, line_d, cur_line;
    logic [LEN_WIDTH-1:0]  len_q, len_d, cur_len, new_len;
    logic                  start, accept, wrap, out_valid_d;

    logic                  out_valid_q, out_eol_q;
    logic [ADDR_WIDTH-1:0] out_col_q;
    logic [DATA_WIDTH-1:0] pix0_q;

    // A sof pixel restarts the frame: it is column 0 of line 0 under the newly latched length.
    assign start   = in_valid & sof;
    assign new_len = (line_len == '0 || line_len > LEN_MAX) ? LEN_MAX : line_len;
    assign cur_col  = start ? '0 : col_q;
    assign cur_line = start ? '0 : line_q;
    assign cur_len  = start ? new_len : len_q;
    assign wrap     = (LEN_WIDTH'(cur_col) == cur_len - LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept && eff_state == ST_FILL && wrap && cur_line == PRE_LAST) begin
            state_d = ST_STREAM;
        end else if (start) begin
            state_d = ST_FILL;
        end
    end

    always_comb begin
        eff_state   = start ? ST_FILL : state_q;
        accept      = in_valid & (start | (state_q != ST_IDLE));
        out_valid_d = accept & ((eff_state == ST_STREAM) | (REPLICATE & (eff_state == ST_FILL)));
    end

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        len_d  = start ? new_len : len_q;
        if (accept) begin
            col_d  = wrap ? '0 : cur_col + ADDR_WIDTH'(1);
            line_d = (wrap && cur_line != LAST_LINE) ? cur_line + LCNT_W'(1) : cur_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            line_q <= '0;
            len_q  <= LEN_MAX;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            len_q  <= len_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_eol_q   <= 1'b0;
            pix0_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            if (accept) begin
                out_col_q <= cur_col;
                out_eol_q <= wrap;
                pix0_q    <= data_in;
            end
        end
    end

    logic [DATA_WIDTH-1:0] ram_wdata [ROWS-1];
    logic [DATA_WIDTH-1:0] ram_old   [ROWS-1];
    logic [DATA_WIDTH-1:0] ram_rd    [ROWS-1];
    logic [DATA_WIDTH-1:0] raw       [ROWS];
    logic [DATA_WIDTH-1:0] unused_old;

    assign unused_old = ram_old[ROWS-2];
    assign raw[0]     = pix0_q;

    // RAM k holds the line k+1 above; each accept pushes every column one RAM deeper.
    for (genvar k = 0; k < ROWS - 1; k++) begin : g_ram
        if (k == 0) begin : g_head
            assign ram_wdata[k] = data_in;
        end else begin : g_chain
            assign ram_wdata[k] = ram_old[k-1];
        end
        assign raw[k+1] = ram_rd[k];

        linebuf_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (MAX_LEN),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (accept),
            .addr_i (cur_col),
            .wdata_i(ram_wdata[k]),
            .old_o  (ram_old[k]),
            .rdata_o(ram_rd[k])
        );
    end

`ifdef LINEBUF_REPLICATE_EN
    logic [LCNT_W-1:0] lines_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lines_q <= '0;
        end else if (accept) begin
            lines_q <= cur_line;
        end
    end

    // Rows not yet received repeat the oldest real row of the frame.
    for (genvar k = 0; k < ROWS; k++) begin : g_out
        if (k == 0) begin : g_cur
            assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = raw[0];
        end else begin : g_rep
            assign data_out[k*DATA_WIDTH +: DATA_WIDTH] =
                (LCNT_W'(k) > lines_q) ? raw[lines_q] : raw[k];
        end
    end
`else
    for (genvar k = 0; k < ROWS; k++) begin : g_out
        assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = raw[k];
    end
`endif

    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;
    assign out_eol   = out_eol_q;

    rows_in_range: assert property (@(posedge clk) (ROWS >= ROWS_MIN) && (ROWS <= ROWS_MAX));

endmodule

// File: tb/tb_linebuf_nrow.sv
// Directed bench for linebuf_nrow: default 3-row build plus a 5-row, 64-pixel instance.
module tb_linebuf_nrow;

    localparam int DW     = 16;
    localparam int ROWS_A = 3;
    localparam int ROWS_B = 5;
`ifdef LINEBUF_REPLICATE_EN
    localparam bit REPL = 1'b1;
`else
    localparam bit REPL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [7:0]         a_len;
    logic               a_sof, a_valid;
    logic [DW-1:0]      a_data;
    logic [ROWS_A*DW-1:0] a_out;
    logic               a_ov, a_eol;
    logic [6:0]         a_col;

    logic [6:0]         b_len;
    logic               b_sof, b_valid;
    logic [DW-1:0]      b_data;
    logic [ROWS_B*DW-1:0] b_out;
    logic               b_ov, b_eol;
    logic [5:0]         b_col;

    linebuf_nrow #(.DATA_WIDTH(DW), .MAX_LEN(128), .ROWS(ROWS_A)) u_dut (
        .clk(clk), .rst(rst), .line_len(a_len), .sof(a_sof), .in_valid(a_valid),
        .data_in(a_data), .data_out(a_out), .out_valid(a_ov), .out_col(a_col), .out_eol(a_eol)
    );

    linebuf_nrow #(.DATA_WIDTH(DW), .MAX_LEN(64), .ROWS(ROWS_B)) u_dut5 (
        .clk(clk), .rst(rst), .line_len(b_len), .sof(b_sof), .in_valid(b_valid),
        .data_in(b_data), .data_out(b_out), .out_valid(b_ov), .out_col(b_col), .out_eol(b_eol)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slice k is pixel (line-k, col); rows above the frame top repeat line 0.
    function automatic logic [127:0] exp_vec(input int line, input int col, input int rows);
        logic [127:0] v;
        int src;
        v = '0;
        for (int k = 0; k < rows; k++) begin
            src = line - k;
            if (src < 0) src = 0;
            v[k*DW +: DW] = DW'(src * 128 + col);
        end
        return v;
    endfunction

    task automatic pix_a(input bit s, input int line, input int col, input int len);
        bit exp_valid;
        a_sof   = s;
        a_valid = 1'b1;
        a_data  = DW'(line * 128 + col);
        @(posedge clk);
        #1;
        a_sof   = 1'b0;
        a_valid = 1'b0;
        exp_valid = REPL || (line >= ROWS_A - 1);
        check("a_valid", a_ov, exp_valid);
        if (exp_valid && a_ov) begin
            check("a_data", a_out, exp_vec(line, col, ROWS_A));
            check("a_col", a_col, col);
            check("a_eol", a_eol, col == len - 1);
        end
    endtask

    task automatic line_a(input int line, input int len, input bit first_sof);
        for (int c = 0; c < len; c++) pix_a(first_sof && c == 0, line, c, len);
    endtask

    task automatic gap_a(input int n);
        a_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("gap_valid", a_ov, 0);
        end
    endtask

    task automatic pix_b(input bit s, input int line, input int col, input int len);
        bit exp_valid;
        b_sof   = s;
        b_valid = 1'b1;
        b_data  = DW'(line * 128 + col);
        @(posedge clk);
        #1;
        b_sof   = 1'b0;
        b_valid = 1'b0;
        exp_valid = REPL || (line >= ROWS_B - 1);
        check("b_valid", b_ov, exp_valid);
        if (exp_valid && b_ov) begin
            check("b_data", b_out, exp_vec(line, col, ROWS_B));
            check("b_col", b_col, col);
            check("b_eol", b_eol, col == len - 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_data"}, a_out, 0);
        check({tag, "_a_valid"}, a_ov, 0);
        check({tag, "_a_col"}, a_col, 0);
        check({tag, "_a_eol"}, a_eol, 0);
    endtask

    initial begin
        rst = 1'b1;
        a_len = 8'd100; a_sof = 1'b0; a_valid = 1'b0; a_data = '0;
        b_len = 7'd64;  b_sof = 1'b0; b_valid = 1'b0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_b_data", b_out, 0);
        check("reset_b_valid", b_ov, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Pixels before any sof are dropped.
        for (int i = 0; i < 3; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(1000 + i);
            @(posedge clk);
            #1;
            a_valid = 1'b0;
            check("idle_drop", a_ov, 0);
        end

        // Fill and stream at 100 pixels, with a 7-cycle stall mid line 2.
        line_a(0, 100, 1'b1);
        line_a(1, 100, 1'b0);
        for (int c = 0; c < 50; c++) pix_a(1'b0, 2, c, 100);
        gap_a(7);
        for (int c = 50; c < 100; c++) pix_a(1'b0, 2, c, 100);
        for (int c = 0; c < 40; c++) pix_a(1'b0, 3, c, 100);

        // Resync at line 3 column 40 with a 50-pixel line; later length changes are ignored.
        a_len = 8'd50;
        pix_a(1'b1, 0, 0, 50);
        a_len = 8'd20;
        for (int c = 1; c < 50; c++) pix_a(1'b0, 0, c, 50);
        line_a(1, 50, 1'b0);
        line_a(2, 50, 1'b0);
        pix_a(1'b0, 3, 0, 50);

        // Zero length clamps to 128.
        a_len = 8'd0;
        line_a(0, 128, 1'b1);
        line_a(1, 128, 1'b0);
        line_a(2, 128, 1'b0);
        for (int c = 0; c < 10; c++) pix_a(1'b0, 3, c, 128);

        // Asynchronous reset mid-line clears outputs without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_valid = 1'b1;
            a_data  = DW'(2000 + i);
            @(posedge clk);
            #1;
            a_valid = 1'b0;
            check("post_rst_drop", a_ov, 0);
        end
        a_len = 8'd4;
        line_a(0, 4, 1'b1);
        line_a(1, 4, 1'b0);
        line_a(2, 4, 1'b0);
        pix_a(1'b0, 3, 0, 4);

        // Five-row instance over 64-pixel lines.
        pix_b(1'b1, 0, 0, 64);
        for (int c = 1; c < 64; c++) pix_b(1'b0, 0, c, 64);
        for (int l = 1; l < 5; l++)
            for (int c = 0; c < 64; c++) pix_b(1'b0, l, c, 64);
        pix_b(1'b0, 5, 0, 64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
